router_input_port: RTL
======================

# router_input_port

Receiving end of the credit-based flit link driven by each processor element (and by neighbouring routers). It buffers incoming 20-bit flits in a small FIFO, computes an XY route for the head flit, presents a one-hot output-port request to the switch allocator, and returns one credit pulse to the sender for every flit that leaves the buffer. One instance sits on every input port of every mesh router.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2; equals the sender's initial credit count
- X_POS, 0, this router's x coordinate (0-3)
- Y_POS, 0, this router's y coordinate (0-3)
- clk  in  1  clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- datain  in  20  flit from sender; [19:18] dest y, [17:16] dest x, [15:0] payload
- in_valid  in  1  datain valid this cycle; one flit per cycle max
- co  out  1  credit return to sender; one-cycle pulse per popped flit
- req  out  5  one-hot port request for head flit: [0] Local, [1] East, [2] West, [3] North, [4] South; 0 when empty
- grant  in  5  one-hot grant from switch allocator
- dataout  out  20  head flit (valid only while out_valid)
- out_valid  out  1  FIFO non-empty
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow  out  1  sticky: a flit arrived while full with no pop

## Operation
- FIFO: DEPTH x 20 storage, write/read pointers of $clog2(DEPTH) bits wrapping modulo DEPTH, occupancy counter 0..DEPTH.
- Push: in_valid=1 at an edge writes datain at wr_ptr, wr_ptr++, unless full and no pop that cycle.
- Pop: at an edge where out_valid=1 and (grant & req) != 0, rd_ptr++ and co=1 in the following cycle.
- Simultaneous push+pop: both occur, count unchanged; legal at full (slot freed same edge) and at empty-with-pop impossible (no req when empty).
- Push while full without pop: flit dropped, FIFO unchanged, overflow set to 1 and held until RST.
- Grant not matching req (grant!=0 and grant&req==0, or grant with >1 bit set): ignored, no pop; bench flags as protocol error.
- Routing (combinational on head flit, dx=dataout[17:16], dy=dataout[19:18]): dx>X_POS → East; dx<X_POS → West; else dy>Y_POS → North; dy<Y_POS → South; else Local. Unsigned 2-bit compares.
- req = route one-hot gated by out_valid; dataout = mem[rd_ptr].
- co is registered: exactly one pulse per pop; back-to-back pops give co high on consecutive cycles.

## Timing
- Reset (RST=1 at an edge): pointers=0, count=0, co=0, overflow=0, out_valid=0, req=0; dataout undefined/don't-care. Flushed flits return no credit (sender resets together).
- RST asserted mid-operation overrides push and pop in that cycle.
- Latency datain→dataout/req: 1 cycle (flit written at edge N is at head, out_valid=1, after edge N when FIFO was empty). No bypass path.
- Pop→co: co=1 during the cycle after the popping edge.
- Pop→next head: new head visible after the popping edge; sustained throughput 1 flit/cycle when grant held.
- count updates at the same edge as push/pop.

## Test plan
- Reset: RST=1 two cycles with in_valid=1 → count=0, out_valid=0, req=5'b0, co=0, overflow=0.
- Routing, X_POS=1,Y_POS=1: push dest (y,x)=(1,3) → req=5'b00010; (1,0) → 5'b00100; (3,1) → 5'b01000; (0,1) → 5'b10000; (1,1) → 5'b00001; each popped with matching grant, co pulses once each.
- Fill/overflow, DEPTH=4: push 5 flits 0xA0001..0xA0005 with grant=0 → count=4, overflow=1 after 5th edge; pop 4 → outputs 0xA0001..0xA0004 in order, 4 co pulses, no 0xA0005.
- Full + simultaneous push/pop: FIFO full, push 0x00077 with valid grant same cycle → count stays 4, overflow stays 0, 0x00077 emerges last after 3 more pops.
- Streaming wrap-around: 12 consecutive flits with grant held matching req → out_valid continuous from cycle 1, 12 co pulses, data order preserved across pointer wrap.
- Bad grant/mid reset: grant=5'b00011 or non-matching bit → no pop, no co; RST asserted with count=3 → count=0 next cycle, no co pulses.

Source files
------------

// File: rtl/router_input_port.sv
// Router input port: buffers incoming flits in a small FIFO, computes the XY route of
// the head flit, raises a one-hot switch request and returns one credit per popped flit.
module router_input_port #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned X_POS = 0,
  parameter int unsigned Y_POS = 0
) (
  input  logic                     clk,
  input  logic                     RST,
  input  logic [19:0]              datain,
  input  logic                     in_valid,
  output logic                     co,
  output logic [4:0]               req,
  input  logic [4:0]               grant,
  output logic [19:0]              dataout,
  output logic                     out_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [1:0] XPos = 2'(X_POS);
  localparam logic [1:0] YPos = 2'(Y_POS);

  localparam logic [4:0] PortLocal = 5'b00001;
  localparam logic [4:0] PortEast  = 5'b00010;
  localparam logic [4:0] PortWest  = 5'b00100;
  localparam logic [4:0] PortNorth = 5'b01000;
  localparam logic [4:0] PortSouth = 5'b10000;

  logic [19:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            co_q, co_d;
  logic            overflow_q, overflow_d;

  logic       full;
  logic       push;
  logic       pop;
  logic [1:0] dx, dy;
  logic [4:0] route;

  assign dataout   = mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign co        = co_q;
  assign overflow  = overflow_q;

  // XY dimension-order routing on the head flit: resolve x first, then y.
  always_comb begin
    dx    = dataout[17:16];
    dy    = dataout[19:18];
    route = PortLocal;
    if (dx > XPos) begin
      route = PortEast;
    end else if (dx < XPos) begin
      route = PortWest;
    end else if (dy > YPos) begin
      route = PortNorth;
    end else if (dy < YPos) begin
      route = PortSouth;
    end
    req = out_valid ? route : 5'b00000;
  end

  // req is one-hot whenever valid, so equality rejects multi-bit and mismatched grants.
  always_comb begin
    full = (count_q == CntW'(DEPTH));
    pop  = out_valid && (grant == req);
    push = in_valid && (!full || pop);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    co_d       = pop;
    overflow_d = overflow_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
    if (in_valid && full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      co_q       <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      co_q       <= co_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (!RST && push) begin
      mem_q[wr_ptr_q] <= datain;
    end
  end

endmodule
